// File: rtl/accelerator_pkg.sv
// Shared OBI widths, the response record carried by the data-memory pipe,
// and the byte-lane write-merge helper.
package accelerator_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  typedef struct packed {
    logic                  valid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

  // Lanes with be=1 take the new byte; others keep the stored byte.
  function automatic logic [OBI_DATA_W-1:0] be_merge(
    input logic [OBI_DATA_W-1:0] old_word,
    input logic [OBI_DATA_W-1:0] new_word,
    input logic [OBI_BE_W-1:0]   be
  );
    logic [OBI_DATA_W-1:0] word;
    word = old_word;
    for (int i = 0; i < OBI_BE_W; i++) begin
      if (be[i]) word[8*i +: 8] = new_word[8*i +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/obi_data_memory_rsp_pipe.sv
// Fixed-latency response delay line: a LATENCY-deep shift register of
// {valid, rdata}, cleared asynchronously so in-flight responses are dropped.
module obi_rsp_pipe
  import accelerator_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     n_reset,
  input  obi_rsp_t rsp_next,
  output obi_rsp_t rsp
);

  obi_rsp_t stage [LATENCY];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= rsp_next;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign rsp = stage[LATENCY-1];

endmodule

// File: rtl/obi_data_memory.sv
// OBI data-memory responder: word SRAM with byte-enable writes, fixed read
// latency, an outstanding-transaction limit and a stall hook on gnt.
module obi_data_memory
  import accelerator_pkg::*;
#(
  parameter int    MEM_WORDS       = 1024,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [OBI_ADDR_W-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [OBI_BE_W-1:0]   data_be_i,
  input  logic [OBI_DATA_W-1:0] data_wdata_i,
  output logic [OBI_DATA_W-1:0] data_rdata_o,
  input  logic                  stall_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("obi_data_memory: LATENCY must be in 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
    $error("obi_data_memory: MAX_OUTSTANDING must be in 1..4");
  end

  logic [OBI_DATA_W-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] outstanding;
  logic             accept;
  logic             retire;
  obi_rsp_t         rsp_next;
  obi_rsp_t         rsp;

  // Request channel: a transaction transfers on a rising edge where req and
  // gnt are both high; gnt is combinational from req, stall and the credit
  // state only. Response channel has no ready: each rvalid is a single-cycle
  // beat the master must take, one per accepted request, in order.
  assign idx        = data_addr_i[IDX_W+1:2];
  assign retire     = rsp.valid;
  assign data_gnt_o = n_reset & data_req_i & ~stall_i &
                      ((outstanding < CNT_W'(MAX_OUTSTANDING)) | retire);
  assign accept     = data_req_i & data_gnt_o;

  always_ff @(posedge clk) begin
    if (accept && data_we_i) mem[idx] <= be_merge(mem[idx], data_wdata_i, data_be_i);
  end

  // Reads sample the stored word before this edge's write lands; since only
  // one request is accepted per cycle there is no read/write collision.
  always_comb begin
    rsp_next.valid = accept;
    rsp_next.rdata = (accept && !data_we_i) ? mem[idx] : '0;
  end

  obi_rsp_pipe #(
    .LATENCY(LATENCY)
  ) u_rsp_pipe (
    .clk      (clk),
    .n_reset  (n_reset),
    .rsp_next (rsp_next),
    .rsp      (rsp)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      outstanding <= '0;
    end else if (accept && !retire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && retire) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  assign data_rvalid_o = rsp.valid;
  assign data_rdata_o  = rsp.rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr_i[OBI_ADDR_W-1:IDX_W+2], data_addr_i[1:0]};

  a_rvalid_has_owner: assert property (
    @(posedge clk) disable iff (!n_reset) data_rvalid_o |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_obi_data_memory.sv
// Bench for obi_data_memory: three instances (L1/M2, L2/M2, L2/M1), a
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_obi_data_memory;

  localparam int MW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        req    [3];
  logic        we     [3];
  logic        stall  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic [3:0]  be     [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // DUTs plus a per-instance reference model: a response is due LATENCY
  // cycles after its grant, and outstanding = responses granted but not yet seen.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int MO  = (g == 2) ? 1 : 2;

    obi_data_memory #(
      .MEM_WORDS       (MW),
      .LATENCY         (LAT),
      .MAX_OUTSTANDING (MO),
      .INIT_FILE       ("")
    ) u_dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .data_req_i    (req[g]),
      .data_gnt_o    (gnt[g]),
      .data_rvalid_o (rvalid[g]),
      .data_addr_i   (addr[g]),
      .data_we_i     (we[g]),
      .data_be_i     (be[g]),
      .data_wdata_i  (wdata[g]),
      .data_rdata_o  (rdata[g]),
      .stall_i       (stall[g])
    );

    logic [31:0] exp_q [$];
    int          due_q [$];
    bit          kn_q  [$];
    logic [31:0] mm    [MW];
    bit          kn    [MW];
    bit          due_now;
    bit          eg;
    int          idx;
    logic [31:0] w;

    initial for (int k = 0; k < MW; k++) kn[k] = 1'b0;

    always @(negedge clk) begin
      if (!n_reset) begin
        exp_q.delete();
        due_q.delete();
        kn_q.delete();
        check($sformatf("u%0d_rst_gnt", g), {31'b0, gnt[g]}, 32'd0);
        check($sformatf("u%0d_rst_rvalid", g), {31'b0, rvalid[g]}, 32'd0);
        check($sformatf("u%0d_rst_rdata", g), rdata[g], 32'd0);
      end else begin
        due_now = (due_q.size() > 0) && (due_q[0] == cyc);
        eg = req[g] && !stall[g] && ((due_q.size() < MO) || due_now);
        check($sformatf("u%0d_gnt", g), {31'b0, gnt[g]}, {31'b0, eg});
        if (due_now) begin
          check($sformatf("u%0d_rvalid", g), {31'b0, rvalid[g]}, 32'd1);
          if (kn_q[0]) check($sformatf("u%0d_rdata", g), rdata[g], exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
          void'(kn_q.pop_front());
        end else begin
          check($sformatf("u%0d_idle_rvalid", g), {31'b0, rvalid[g]}, 32'd0);
          check($sformatf("u%0d_idle_rdata", g), rdata[g], 32'd0);
        end
        if (eg) begin
          idx = int'((addr[g] >> 2) % MW);
          if (we[g]) begin
            w = mm[idx];
            for (int l = 0; l < 4; l++) if (be[g][l]) w[8*l +: 8] = wdata[g][8*l +: 8];
            mm[idx] = w;
            kn[idx] = kn[idx] || (be[g] == 4'hF);
            exp_q.push_back(32'd0);
            kn_q.push_back(1'b1);
          end else begin
            exp_q.push_back(mm[idx]);
            kn_q.push_back(kn[idx]);
          end
          due_q.push_back(cyc + LAT);
        end
      end
    end
  end

  task automatic drive(input int i, input logic r, input logic w_en, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[i] = r; we[i] = w_en; addr[i] = a; be[i] = b; wdata[i] = d;
  endtask

  // One handshake on instance i; returns read data and cycles from grant to rvalid.
  task automatic xfer(input int i, input logic w_en, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk); #1;
    drive(i, 1'b1, w_en, a, b, d);
    n = 0;
    @(negedge clk);
    while (!gnt[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!gnt[i]) check($sformatf("u%0d_xfer_gnt_timeout", i), 32'd0, 32'd1);
    @(posedge clk); #1;
    req[i] = 1'b0;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rvalid[i]) begin
        lat = k;
        rd  = rdata[i];
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [9:0]  gp1, gp2, rp1, rp2;
    int          cnt1, cnt2;
    bit          seen;

    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0);
      stall[i] = 1'b0;
    end

    // Reset with requests pending, then grant in the first released cycle.
    for (int i = 0; i < 3; i++) req[i] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_reset_gnt", i), {31'b0, gnt[i]}, 32'd0);
      check($sformatf("u%0d_reset_rdata", i), rdata[i], 32'd0);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("u%0d_release_gnt", i), {31'b0, gnt[i]}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    repeat (4) @(posedge clk);

    // Directed vectors on the LATENCY=1 instance.
    tbl[0] = '{1'b1, 32'h0000_1000, 4'hF, 32'hA5A5_0001, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 32'hA5A5_0001};
    tbl[2] = '{1'b1, 32'h0000_2008, 4'hF, 32'h1122_3344, 32'h0000_0000};
    tbl[3] = '{1'b1, 32'h0000_2008, 4'b0100, 32'h00CC_0000, 32'h0000_0000};
    tbl[4] = '{1'b0, 32'h0000_2008, 4'h0, 32'h0000_0000, 32'h11CC_3344};
    tbl[5] = '{1'b1, 32'h0000_2008, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6] = '{1'b0, 32'h0000_2008, 4'hF, 32'h0000_0000, 32'h11CC_3344};
    tbl[7] = '{1'b1, MW * 4 + 4, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[8] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};
    tbl[9] = '{1'b0, 32'h0000_1003, 4'hF, 32'h0000_0000, 32'hA5A5_0001};
    for (int v = 0; v < 10; v++) begin
      xfer(0, tbl[v].we, tbl[v].addr, tbl[v].be, tbl[v].wdata, rd, lat);
      check($sformatf("tbl%0d_rdata", v), rd, tbl[v].exp);
      check($sformatf("tbl%0d_latency", v), lat, 32'd1);
    end

    // Four back-to-back reads on both LATENCY=2 instances.
    gp1 = '0; gp2 = '0; rp1 = '0; rp2 = '0; cnt1 = 0; cnt2 = 0;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
    drive(2, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gp1[k] = gnt[1]; rp1[k] = rvalid[1];
      gp2[k] = gnt[2]; rp2[k] = rvalid[2];
      if (gnt[1]) cnt1++;
      if (gnt[2]) cnt2++;
      @(posedge clk); #1;
      if (cnt1 == 4) req[1] = 1'b0;
      if (cnt2 == 4) req[2] = 1'b0;
    end
    check("tput_m2_gnt", {22'b0, gp1}, 32'b00_0000_1111);
    check("tput_m2_rvalid", {22'b0, rp1}, 32'b00_0011_1100);
    check("tput_m1_gnt", {22'b0, gp2}, 32'b00_0101_0101);
    check("tput_m1_rvalid", {22'b0, rp2}, 32'b01_0101_0100);
    repeat (3) @(posedge clk);

    // Stall: pass 0 abandons the stalled write, pass 1 lets it through.
    xfer(0, 1'b1, 32'h0000_0030, 4'hF, 32'h0102_0304, rd, lat);
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      stall[0] = 1'b1;
      drive(0, 1'b1, 1'b1, 32'h0000_0030, 4'hF, 32'hCAFE_F00D);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("stall_gnt", {31'b0, gnt[0]}, 32'd0);
        @(posedge clk); #1;
      end
      stall[0] = 1'b0;
      if (p == 0) begin
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        xfer(0, 1'b0, 32'h0000_0030, 4'hF, 32'd0, rd, lat);
        check("stall_mem_unchanged", rd, 32'h0102_0304);
      end else begin
        @(negedge clk);
        check("stall_release_gnt", {31'b0, gnt[0]}, 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        repeat (3) @(posedge clk);
        xfer(0, 1'b0, 32'h0000_0030, 4'hF, 32'd0, rd, lat);
        check("stall_mem_written", rd, 32'hCAFE_F00D);
      end
    end

    // Reset between grant and rvalid: response dropped, memory kept.
    xfer(1, 1'b1, 32'h0000_0040, 4'hF, 32'h5A5A_1234, rd, lat);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'd0);
    @(negedge clk);
    check("midrst_gnt", {31'b0, gnt[1]}, 32'd1);
    @(posedge clk); #1;
    req[1]  = 1'b0;
    n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid[1]) seen = 1'b1;
    end
    check("midrst_rvalid_dropped", {31'b0, seen}, 32'd0);
    xfer(1, 1'b0, 32'h0000_0040, 4'hF, 32'd0, rd, lat);
    check("midrst_mem_kept", rd, 32'h5A5A_1234);
    check("midrst_latency", lat, 32'd2);

    // Random traffic on all three instances against the reference models.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        drive(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
              4'($urandom_range(0, 15)), $urandom);
        stall[i] = ($urandom_range(0, 7) == 0);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      req[i]   = 1'b0;
      stall[i] = 1'b0;
    end
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
